// File: rtl/noc_port_pkg.sv
// Shared constants and helpers for the tile-side network interface.
// Flit width tracks the mesh DATA_WIDTH so the port and router always agree.
package noc_port_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int FLIT_W        = DATA_WIDTH;
    localparam int DEF_INJ_DEPTH = 4;
    localparam int DEF_CREDITS   = 4;
    localparam int DEF_EJ_DEPTH  = 4;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_port_fifo.sv
// Synchronous FIFO used for both the injection and ejection buffers.
// A pop frees a slot in the same cycle, so a push into a full FIFO with a pop is accepted.
module noc_port_fifo
    import noc_port_pkg::*;
#(
    parameter int WIDTH = FLIT_W,
    parameter int DEPTH = DEF_INJ_DEPTH
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/noc_tile_port.sv
// Tile network interface: credit-based injection into the router P port and
// buffered ejection to the tile with one yummy returned per consumed flit.
module noc_tile_port
    import noc_port_pkg::*;
#(
    parameter int DATA_W    = FLIT_W,
    parameter int INJ_DEPTH = DEF_INJ_DEPTH,
    parameter int CREDITS   = DEF_CREDITS,
    parameter int EJ_DEPTH  = DEF_EJ_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic [DATA_W-1:0]              noc_data_out,
    output logic                           noc_valid_out,
    input  logic                           noc_yummy_in,
    input  logic [DATA_W-1:0]              noc_data_in,
    input  logic                           noc_valid_in,
    output logic                           noc_yummy_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [clog2(CREDITS+1)-1:0]    credit_cnt,
    output logic                           err
);

    localparam int                CNT_W       = clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0]  CREDITS_MAX = CNT_W'(CREDITS);

    logic [DATA_W-1:0] inj_head;
    logic              inj_full, inj_empty, inj_push;
    logic              ej_full, ej_empty, ej_pop;
    logic              send;

    logic [CNT_W-1:0]  credit_q, credit_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              yummy_q, yummy_d;
    logic              err_q, err_d;

    // Injection side
    assign in_ready = ~reset_in & ~inj_full;
    assign inj_push = in_valid & in_ready;

    // An incoming yummy counts toward this cycle's send decision.
    assign send = ~inj_empty & ((credit_q != '0) | noc_yummy_in);

    noc_port_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk         (clk),
        .reset_in    (reset_in),
        .push_i      (inj_push),
        .push_data_i (in_data),
        .pop_i       (send),
        .head_o      (inj_head),
        .full_o      (inj_full),
        .empty_o     (inj_empty)
    );

    // Ejection side
    assign out_valid = ~ej_empty;
    assign ej_pop    = out_valid & out_ready;

    noc_port_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk         (clk),
        .reset_in    (reset_in),
        .push_i      (noc_valid_in),
        .push_data_i (noc_data_in),
        .pop_i       (ej_pop),
        .head_o      (out_data),
        .full_o      (ej_full),
        .empty_o     (ej_empty)
    );

    always_comb begin
        credit_d    = credit_q;
        data_out_d  = data_out_q;
        valid_out_d = send;
        yummy_d     = ej_pop;
        err_d       = err_q;

        if (send) begin
            data_out_d = inj_head;
        end

        if (send && !noc_yummy_in) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (!send && noc_yummy_in) begin
            if (credit_q == CREDITS_MAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CNT_W'(1);
            end
        end

        // A flit arriving at a full buffer with nothing leaving is lost.
        if (noc_valid_in && ej_full && !ej_pop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            credit_q    <= CREDITS_MAX;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            yummy_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            yummy_q     <= yummy_d;
            err_q       <= err_d;
        end
    end

    assign credit_cnt    = credit_q;
    assign noc_data_out  = data_out_q;
    assign noc_valid_out = valid_out_q;
    assign noc_yummy_out = yummy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_noc_tile_port.sv
// Bench for noc_tile_port: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based model of the port.
module tb_noc_tile_port;

    localparam int DW        = 64;
    localparam int INJ_DEPTH = 4;
    localparam int CREDITS   = 4;
    localparam int EJ_DEPTH  = 4;

    logic          clk;
    logic          reset_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] noc_data_out;
    logic          noc_valid_out;
    logic          noc_yummy_in;
    logic [DW-1:0] noc_data_in;
    logic          noc_valid_in;
    logic          noc_yummy_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    credit_cnt;
    logic          err;

    noc_tile_port #(
        .DATA_W    (DW),
        .INJ_DEPTH (INJ_DEPTH),
        .CREDITS   (CREDITS),
        .EJ_DEPTH  (EJ_DEPTH)
    ) dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .noc_data_out  (noc_data_out),
        .noc_valid_out (noc_valid_out),
        .noc_yummy_in  (noc_yummy_in),
        .noc_data_in   (noc_data_in),
        .noc_valid_in  (noc_valid_in),
        .noc_yummy_out (noc_yummy_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .credit_cnt    (credit_cnt),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] inj_q[$];
    logic [DW-1:0] ej_q[$];
    int            m_cred   = CREDITS;
    logic          m_err    = 1'b0;
    logic          m_valid  = 1'b0;
    logic [DW-1:0] m_data   = '0;
    logic          m_yummy  = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model on the sampled inputs, then compare.
    task automatic cycle();
        logic [DW-1:0] tmp;
        int            inj_n;
        logic          send;
        logic          pop;
        @(posedge clk);
        if (reset_in) begin
            inj_q.delete();
            ej_q.delete();
            m_cred  = CREDITS;
            m_err   = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            m_yummy = 1'b0;
        end else begin
            inj_n = inj_q.size();
            send  = (inj_n > 0) && ((m_cred > 0) || noc_yummy_in);
            m_valid = send;
            if (send) m_data = inj_q.pop_front();
            if (in_valid && inj_n < INJ_DEPTH) inj_q.push_back(in_data);
            if (send && !noc_yummy_in) m_cred--;
            else if (!send && noc_yummy_in) begin
                if (m_cred == CREDITS) m_err = 1'b1;
                else m_cred++;
            end
            pop = (ej_q.size() > 0) && out_ready;
            if (pop) tmp = ej_q.pop_front();
            if (noc_valid_in) begin
                if (ej_q.size() < EJ_DEPTH) ej_q.push_back(noc_data_in);
                else m_err = 1'b1;
            end
            m_yummy = pop;
        end
        #1;
        chk("noc_valid_out", noc_valid_out, m_valid);
        chk("noc_data_out", noc_data_out, m_data);
        chk("credit_cnt", credit_cnt, m_cred);
        chk("noc_yummy_out", noc_yummy_out, m_yummy);
        chk("err", err, m_err);
        chk("in_ready", in_ready, !reset_in && inj_q.size() < INJ_DEPTH);
        chk("out_valid", out_valid, ej_q.size() > 0);
        if (ej_q.size() > 0) chk("out_data", out_data, ej_q[0]);
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        cycle();
        reset_in = 1'b0;
    endtask

    int            accepted;
    int            pulses;
    int            yums;
    int            router_owed;
    int            router_cred;
    logic [DW-1:0] popped[$];

    initial begin
        reset_in     = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        noc_yummy_in = 1'b0;
        noc_data_in  = '0;
        noc_valid_in = 1'b0;
        out_ready    = 1'b0;

        // Reset state
        cycle();
        cycle();
        chk("reset_in_ready_low", in_ready, 1'b0);
        reset_in = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);
        chk("reset_credit", credit_cnt, CREDITS);
        cycle();

        // Single flit: accepted at edge 1, on the link after edge 2
        in_valid = 1'b1;
        in_data  = 64'hA5;
        cycle();
        chk("single_not_early", noc_valid_out, 1'b0);
        in_valid = 1'b0;
        cycle();
        chk("single_valid", noc_valid_out, 1'b1);
        chk("single_data", noc_data_out, 64'hA5);
        chk("single_credit", credit_cnt, 3);
        cycle();
        chk("single_one_pulse", noc_valid_out, 1'b0);
        noc_yummy_in = 1'b1;
        cycle();
        noc_yummy_in = 1'b0;

        // Credit exhaustion: 6 flits, no yummies
        accepted = 0;
        pulses   = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = (accepted < 6);
            in_data  = DW'(100 + accepted);
            if (in_valid && inj_q.size() < INJ_DEPTH) accepted++;
            cycle();
            if (noc_valid_out) pulses++;
        end
        in_valid = 1'b0;
        chk("exhaust_accepted", accepted, 6);
        chk("exhaust_pulses", pulses, 4);
        chk("exhaust_credit", credit_cnt, 0);
        pulses = 0;
        noc_yummy_in = 1'b1;
        cycle();
        if (noc_valid_out) pulses++;
        cycle();
        if (noc_valid_out) pulses++;
        noc_yummy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (noc_valid_out) pulses++;
        end
        chk("refill_pulses", pulses, 2);
        chk("refill_credit", credit_cnt, 0);
        noc_yummy_in = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        noc_yummy_in = 1'b0;
        chk("restored_credit", credit_cnt, CREDITS);

        // Send and yummy in the same cycle
        in_valid = 1'b1;
        in_data  = 64'h1111;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("simul_pre_credit", credit_cnt, 3);
        in_valid = 1'b1;
        in_data  = 64'h2222;
        cycle();
        in_valid     = 1'b0;
        noc_yummy_in = 1'b1;
        cycle();
        noc_yummy_in = 1'b0;
        chk("simul_sent", noc_valid_out, 1'b1);
        chk("simul_credit", credit_cnt, 3);
        noc_yummy_in = 1'b1;
        cycle();
        noc_yummy_in = 1'b0;

        // Ejection backpressure
        out_ready = 1'b0;
        yums = 0;
        for (int k = 1; k <= 4; k++) begin
            noc_valid_in = 1'b1;
            noc_data_in  = DW'(k);
            cycle();
            if (noc_yummy_out) yums++;
        end
        noc_valid_in = 1'b0;
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_out_data", out_data, 1);
        chk("bp_no_yummy", yums, 0);
        out_ready = 1'b1;
        popped.delete();
        for (int i = 0; i < 6; i++) begin
            if (out_valid) popped.push_back(out_data);
            cycle();
            if (noc_yummy_out) yums++;
        end
        chk("bp_yummies", yums, 4);
        chk("bp_pop_count", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("bp_order", popped[i], DW'(i + 1));
        out_ready = 1'b0;

        // Overflowing the ejection buffer
        for (int k = 11; k <= 15; k++) begin
            noc_valid_in = 1'b1;
            noc_data_in  = DW'(k);
            cycle();
        end
        noc_valid_in = 1'b0;
        chk("ej_overflow_err", err, 1'b1);
        out_ready = 1'b1;
        popped.delete();
        for (int i = 0; i < 6; i++) begin
            if (out_valid) popped.push_back(out_data);
            cycle();
        end
        chk("ej_drop_count", popped.size(), 4);
        if (popped.size() > 0) chk("ej_drop_last", popped[popped.size() - 1], 14);
        out_ready = 1'b0;
        do_reset();
        chk("err_cleared", err, 1'b0);

        // Yummy with full credits
        noc_yummy_in = 1'b1;
        cycle();
        noc_yummy_in = 1'b0;
        chk("credit_over_err", err, 1'b1);
        chk("credit_saturated", credit_cnt, CREDITS);
        cycle();
        chk("err_sticky", err, 1'b1);
        do_reset();

        // Reset with flits buffered in both directions
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid     = (accepted < 6);
            in_data      = DW'(200 + accepted);
            if (in_valid && inj_q.size() < INJ_DEPTH) accepted++;
            noc_valid_in = (i < 2);
            noc_data_in  = DW'(300 + i);
            cycle();
        end
        in_valid     = 1'b0;
        noc_valid_in = 1'b0;
        chk("mid_inj_held", inj_q.size(), 2);
        chk("mid_ej_held", out_valid, 1'b1);
        reset_in = 1'b1;
        cycle();
        chk("mid_reset_credit", credit_cnt, CREDITS);
        chk("mid_reset_out_valid", out_valid, 1'b0);
        chk("mid_reset_valid_out", noc_valid_out, 1'b0);
        chk("mid_reset_data_out", noc_data_out, 0);
        reset_in  = 1'b0;
        out_ready = 1'b1;
        pulses = 0;
        yums   = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (noc_valid_out) pulses++;
            if (noc_yummy_out) yums++;
        end
        chk("mid_no_stale_send", pulses, 0);
        chk("mid_no_spurious_yummy", yums, 0);

        // Random traffic against a credit-honouring router
        do_reset();
        router_owed = 0;
        router_cred = EJ_DEPTH;
        for (int i = 0; i < 600; i++) begin
            in_valid     = 1'($urandom_range(0, 1));
            in_data      = {$urandom, $urandom};
            noc_yummy_in = (router_owed > 0) && ($urandom_range(0, 2) != 0);
            if (noc_yummy_in) router_owed--;
            noc_valid_in = (router_cred > 0) && ($urandom_range(0, 1) == 1);
            if (noc_valid_in) router_cred--;
            noc_data_in  = {$urandom, $urandom};
            out_ready    = ($urandom_range(0, 3) != 0);
            cycle();
            if (noc_valid_out) router_owed++;
            if (noc_yummy_out) router_cred++;
        end
        chk("random_no_err", err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
